// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation at a time, drives registered
// operands to an external ALU, lets MUL/DIV settle for a fixed number of
// cycles, captures the 64-bit result and holds it until the consumer takes it.
module alu_sequencer #(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_y,
  output logic [31:0] alu_bus,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] ops_done
);

  localparam int unsigned MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
  localparam int          CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_LAST = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               req_err;
  logic [CNT_W-1:0]   req_wait;

  // Classify the presented request: rejected opcode/zero divisor, and settle time.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    req_err  = (req_op > OP_LAST) || ((req_op == OP_DIV) && (req_b == 32'd0));
    req_wait = '0;
    if (req_op == OP_MUL) req_wait = CNT_W'(MUL_WAIT);
    if (req_op == OP_DIV) req_wait = CNT_W'(DIV_WAIT);
  end

  // Sequencer FSM with registered handshake/status outputs and datapath registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state     <= IDLE;
      wait_cnt  <= '0;
      alu_y     <= '0;
      alu_bus   <= '0;
      alu_op    <= '0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_err   <= 1'b0;
      ops_done  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_op    <= req_op;
            alu_y     <= req_a;
            alu_bus   <= req_b;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_err) begin
              // Rejected ops skip the ALU entirely and report a zero result.
              rsp_lo    <= '0;
              rsp_hi    <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              wait_cnt <= req_wait;
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            // Capture all 64 bits regardless of op; the ALU owns the hi-word rules.
            rsp_hi    <= alu_c[63:32];
            rsp_lo    <= alu_c[31:0];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done  <= ops_done + 16'd1;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_WAIT, default 2: extra settle cycles granted to MUL (op 4'b0110) before result capture.
REQ-002 Parameter DIV_WAIT, default 4: extra settle cycles granted to DIV (op 4'b0111) before result capture.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  requester presents an operation.
REQ-006 req_ready  output  1  sequencer can accept an operation.
REQ-007 req_op  input  4  ALU opcode, same encoding as the ALU (AND=0 through ROL=12).
REQ-008 req_a  input  32  first operand, routed to the ALU Y input.
REQ-009 req_b  input  32  second operand, routed to the ALU BusMuxOut input.
REQ-010 alu_y, alu_bus  output  32 each  registered operands driven to the ALU.
REQ-011 alu_op  output  4  registered opcode driven to the ALU.
REQ-012 alu_c  input  64  ALU result (hi = [63:32], lo = [31:0]).
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts the result.
REQ-015 rsp_lo, rsp_hi  output  32 each  captured result (Z low and Z high).
REQ-016 rsp_err  output  1  operation rejected (illegal opcode or divide by zero).
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 ops_done  output  16  count of completed responses.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-021 Accept: on an edge in IDLE with req_valid=1, the block SHALL register req_op, req_a and req_b into alu_op, alu_y and alu_bus.
REQ-022 On accept with a legal opcode and no error, the block SHALL load wait_cnt (MUL_WAIT for MUL, DIV_WAIT for DIV, else 0) and go to EXEC.
REQ-023 On accept with req_op in 13..15, or DIV with req_b=0, the block SHALL go directly to RESP with rsp_err=1 and rsp_lo=rsp_hi=0.
REQ-024 In EXEC with wait_cnt>0, the block SHALL decrement wait_cnt.
REQ-025 In EXEC with wait_cnt=0, the block SHALL capture alu_c into rsp_hi/rsp_lo, set rsp_err=0 and go to RESP.
REQ-026 Latency: for an accept at edge k, rsp_valid SHALL rise after edge k+1+W, where W is the op's wait count.
REQ-027 For an error, rsp_valid SHALL rise after edge k.
REQ-028 In RESP, rsp_lo, rsp_hi and rsp_err SHALL hold stable until rsp_ready=1.
REQ-029 On the RESP edge with rsp_ready=1, the block SHALL go to IDLE and increment ops_done (wrapping 16'hFFFF to 0); no new accept occurs on that edge.
REQ-030 req_valid SHALL be ignored whenever not in IDLE; operands and opcode are not altered.
REQ-031 alu_y, alu_bus and alu_op SHALL hold their captured values from accept until the next accept.
REQ-032 rsp_lo, rsp_hi and rsp_err SHALL hold their last values in IDLE.
REQ-033 Operands are passed unmodified; for SUB the ALU computes alu_y - alu_bus, and for DIV alu_y / alu_bus.
REQ-034 The block SHALL NOT alter the ALU result width rules: hi is zero for non-MUL/DIV ops as produced by the ALU, and the block SHALL capture all 64 bits regardless of op.

Reset
REQ-035 clear=0 SHALL immediately (asynchronously) force state IDLE, wait_cnt=0, alu_y=alu_bus=0, alu_op=0, rsp_lo=rsp_hi=0, rsp_err=0, ops_done=0.
REQ-036 During reset, req_ready SHALL be 1, rsp_valid 0 and busy 0.
REQ-037 Reset asserted in EXEC or RESP SHALL abandon the operation with no response and no ops_done increment.
REQ-038 The first accept SHALL be possible on the first rising edge after clear deasserts.

Verification
REQ-039 ADD: a=5, b=7, rsp_ready=1 -> rsp_valid after edge k+1; rsp_lo=12, rsp_hi=0, rsp_err=0, ops_done=1.
REQ-040 MUL (defaults): a=b=32'h0001_0000 -> rsp_valid after edge k+3; rsp_hi=1, rsp_lo=0.
REQ-041 DIV: a=17, b=5 -> rsp_valid after edge k+5; rsp_lo=3, rsp_hi=2. DIV with b=0 -> rsp_err=1, lo=hi=0, rsp_valid after edge k.
REQ-042 Illegal op 4'hE -> rsp_err=1, lo=hi=0; ALU result not captured; ops_done still increments on rsp_ready.
REQ-043 Backpressure: hold rsp_ready=0 for 3 cycles after a SUB a=10, b=3 while pulsing req_valid with new operands -> rsp_lo=7 stable, req_ready=0, alu_y=10 unchanged; IDLE reached on the edge where rsp_ready=1.
REQ-044 Reset mid-DIV: drop clear during EXEC -> outputs take reset values immediately, no response, ops_done=0; a subsequent ADD 1+1 returns 2.
